alu_pipe: RTL and testbench

- Parametrised, registered ALU for the next-generation datapath. Width is set by parameter; operation is selected by a decoded 4-bit opcode rather than raw instruction bits.
- Adds valid/ready handshakes on input and output, a one-entry output register with backpressure, compare/set ops with 1-bit results, and an iterative multi-cycle multiplier.
- Sits between the decode/operand-forwarding stage and the memory stage. One operation in flight at a time.

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 169 ++++++++++++++++
 tb/tb_alu_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake/operand/result bundle between the forwarding stage, alu_pipe and the memory stage.
// master drives operands and out_ready; slave (the ALU) drives in_ready and the result side.
interface alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             sign;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             ofl;
   logic             zero;
   logic             cout;
   logic             err;

   modport master (
      output in_valid, a, b, op, sign, out_ready,
      input  in_ready, out_valid, result, ofl, zero, cout, err
   );

   modport slave (
      input  in_valid, a, b, op, sign, out_ready,
      output in_ready, out_valid, result, ofl, zero, cout, err
   );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU, one op in flight, one-entry output register with valid/ready backpressure.
// ALU_PIPE_MUL_EN builds the iterative shift-add multiplier (op D); otherwise op D is illegal.
module alu_pipe #(
   parameter int  WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst,
   alu_pipe_if.slave bus
);
   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_ANDN = 4'h3,
                          OP_OR  = 4'h4, OP_ROL = 4'h5, OP_SLL = 4'h6, OP_ROR  = 4'h7,
                          OP_SRL = 4'h8, OP_SEQ = 4'h9, OP_SLT = 4'hA, OP_SLE  = 4'hB,
                          OP_SCO = 4'hC;

   typedef enum logic {IDLE, MUL_BUSY} state_e;

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ofl_q, ofl_d, zero_q, zero_d, cout_q, cout_d, err_q, err_d;

   logic             accept, is_mul;
   logic [WIDTH-1:0] bb, alu_res;
   logic [WIDTH:0]   sum;
   logic [2*WIDTH-1:0] rol_w, ror_w;
   logic [SHW-1:0]   shamt;
   logic             c_msb, alu_ofl, alu_cout, alu_err;

`ifdef ALU_PIPE_MUL_EN
   localparam logic [3:0] OP_MUL = 4'hD;
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_next;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   assign is_mul = (bus.op == OP_MUL);
`else
   assign is_mul = 1'b0;
`endif

   assign bus.in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.ofl       = ofl_q;
   assign bus.zero      = zero_q;
   assign bus.cout      = cout_q;
   assign bus.err       = err_q;

   // One shared adder serves ADD, SUB (a + ~b + 1) and SCO.
   always_comb begin
      bb       = (bus.op == OP_SUB) ? ~bus.b : bus.b;
      sum      = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, (bus.op == OP_SUB)};
      c_msb    = bus.a[WIDTH-1] ^ bb[WIDTH-1] ^ sum[WIDTH-1];
      shamt    = bus.b[SHW-1:0];
      rol_w    = {bus.a, bus.a} << shamt;
      ror_w    = {bus.a, bus.a} >> shamt;
      alu_res  = '0;
      alu_ofl  = 1'b0;
      alu_cout = 1'b0;
      alu_err  = 1'b0;
      case (bus.op)
         OP_ADD, OP_SUB: begin
            alu_res  = sum[WIDTH-1:0];
            alu_cout = sum[WIDTH];
            alu_ofl  = bus.sign ? (c_msb ^ sum[WIDTH]) : sum[WIDTH];
         end
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_ANDN: alu_res = bus.a & ~bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
         OP_SLL:  alu_res = bus.a << shamt;
         OP_ROR:  alu_res = ror_w[WIDTH-1:0];
         OP_SRL:  alu_res = bus.a >> shamt;
         OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <  $signed(bus.b))};
         OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <= $signed(bus.b))};
         OP_SCO: begin
            alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            alu_cout = sum[WIDTH];
         end
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      result_d    = result_q;
      ofl_d       = ofl_q;
      zero_d      = zero_q;
      cout_d      = cout_q;
      err_d       = err_q;
      if (accept && !is_mul) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         ofl_d       = alu_ofl;
         zero_d      = (alu_res == '0);
         cout_d      = alu_cout;
         err_d       = alu_err;
      end
`ifdef ALU_PIPE_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
      case (state_q)
         IDLE: begin
            if (accept && is_mul) begin
               state_d  = MUL_BUSY;
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, bus.a};
               mplier_d = bus.b;
               cnt_d    = SHW'(WIDTH - 1);
            end
         end
         MUL_BUSY: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            // The final partial product is folded in combinationally so the result lands on count 0.
            if (cnt_q == '0) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               result_d    = acc_next[WIDTH-1:0];
               ofl_d       = |acc_next[2*WIDTH-1:WIDTH];
               zero_d      = (acc_next[WIDTH-1:0] == '0);
               cout_d      = 1'b0;
               err_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ofl_q       <= 1'b0;
         zero_q      <= 1'b0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         ofl_q       <= ofl_d;
         zero_q      <= zero_d;
         cout_q      <= cout_d;
         err_q       <= err_d;
`ifdef ALU_PIPE_MUL_EN
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: reset, every opcode, backpressure, back-to-back issue, MUL when built.
// Each check packs {out_valid, result, ofl, zero, cout, err} against hand-computed values.
module tb_alu_pipe;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alu_pipe_if #(.WIDTH(W)) bus ();
   alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] out_pack();
      return {11'd0, bus.out_valid, bus.result, bus.ofl, bus.zero, bus.cout, bus.err};
   endfunction

   function automatic logic [31:0] exp_pack(input logic [15:0] res, input logic o, input logic z,
                                            input logic c, input logic e);
      return {11'd0, 1'b1, res, o, z, c, e};
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic s);
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.sign     = s;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int n;
      logic seen;

      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op        = 4'h0;
      bus.a         = 16'h0007;
      bus.b         = 16'h0001;
      bus.sign      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("post_rst_outputs", out_pack(), 32'd0);

      do_op(4'h0, 16'h7FFF, 16'h0001, 1'b1); chk("add_sovf", out_pack(), exp_pack(16'h8000, 1, 0, 0, 0));
      do_op(4'h1, 16'h0005, 16'h0005, 1'b0); chk("sub_uns",  out_pack(), exp_pack(16'h0000, 1, 1, 1, 0));
      do_op(4'h1, 16'h0005, 16'h0005, 1'b1); chk("sub_sgn",  out_pack(), exp_pack(16'h0000, 0, 1, 1, 0));
      do_op(4'h2, 16'h0F0F, 16'h00FF, 1'b0); chk("xor",      out_pack(), exp_pack(16'h0FF0, 0, 0, 0, 0));
      do_op(4'h3, 16'hF0F0, 16'hFF00, 1'b0); chk("andn",     out_pack(), exp_pack(16'h00F0, 0, 0, 0, 0));
      do_op(4'h4, 16'h1200, 16'h0034, 1'b0); chk("or",       out_pack(), exp_pack(16'h1234, 0, 0, 0, 0));
      do_op(4'h5, 16'h8001, 16'h0004, 1'b0); chk("rol",      out_pack(), exp_pack(16'h0018, 0, 0, 0, 0));
      do_op(4'h6, 16'h00F0, 16'h0014, 1'b0); chk("sll",      out_pack(), exp_pack(16'h0F00, 0, 0, 0, 0));
      do_op(4'h7, 16'h0001, 16'h0001, 1'b0); chk("ror",      out_pack(), exp_pack(16'h8000, 0, 0, 0, 0));
      do_op(4'h8, 16'h8000, 16'h000F, 1'b0); chk("srl",      out_pack(), exp_pack(16'h0001, 0, 0, 0, 0));
      do_op(4'h9, 16'h1234, 16'h1234, 1'b0); chk("seq_t",    out_pack(), exp_pack(16'h0001, 0, 0, 0, 0));
      do_op(4'h9, 16'h1234, 16'h1235, 1'b0); chk("seq_f",    out_pack(), exp_pack(16'h0000, 0, 1, 0, 0));
      do_op(4'hA, 16'hFFFF, 16'h0001, 1'b0); chk("slt_t",    out_pack(), exp_pack(16'h0001, 0, 0, 0, 0));
      do_op(4'hA, 16'h0001, 16'hFFFF, 1'b0); chk("slt_f",    out_pack(), exp_pack(16'h0000, 0, 1, 0, 0));
      do_op(4'hB, 16'h1234, 16'h1234, 1'b0); chk("sle_eq",   out_pack(), exp_pack(16'h0001, 0, 0, 0, 0));
      do_op(4'hC, 16'hFFFF, 16'h0001, 1'b0); chk("sco",      out_pack(), exp_pack(16'h0001, 0, 0, 1, 0));
      do_op(4'hE, 16'h1111, 16'h2222, 1'b0); chk("illegal_e", out_pack(), exp_pack(16'h0000, 0, 1, 0, 1));
      do_op(4'h0, 16'h0002, 16'h0003, 1'b0); chk("err_clears", out_pack(), exp_pack(16'h0005, 0, 0, 0, 0));

      // Back-to-back: in_valid held high, one result per cycle.
      bus.op       = 4'h0;
      bus.sign     = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.a = 16'(i + 1);
         bus.b = 16'(i * 3);
         #1;
         chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
         @(posedge clk);
         #1;
         chk("b2b_result", out_pack(), exp_pack(16'(4 * i + 1), 0, 0, 0, 0));
      end
      bus.in_valid = 1'b0;

      // Backpressure: held result stays stable and a pending op is not taken.
      do_op(4'h0, 16'h0003, 16'h0004, 1'b0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.a         = 16'h0010;
      bus.b         = 16'h0020;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_hold", out_pack(), exp_pack(16'h0007, 0, 0, 0, 0));
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk("bp_release_op", out_pack(), exp_pack(16'h0030, 0, 0, 0, 0));
      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef ALU_PIPE_MUL_EN
      do_op(4'hD, 16'h0012, 16'h0034, 1'b0);
      chk("mul_busy_ready", {31'd0, bus.in_ready}, 32'd0);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("mul_latency", n, 32'd16);
      chk("mul_small", out_pack(), exp_pack(16'h03A8, 0, 0, 0, 0));

      do_op(4'hD, 16'h0100, 16'h0100, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("mul_latency2", n, 32'd16);
      chk("mul_ovf", out_pack(), exp_pack(16'h0000, 1, 1, 0, 0));

      do_op(4'hD, 16'hFFFF, 16'hFFFF, 1'b0);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         if (bus.out_valid) seen = 1'b1;
         tick();
      end
      chk("mul_abort_no_valid", {31'd0, seen}, 32'd0);
      chk("mul_abort_idle", {31'd0, bus.in_ready}, 32'd1);
`else
      do_op(4'hD, 16'h0012, 16'h0034, 1'b0);
      chk("mul_disabled", out_pack(), exp_pack(16'h0000, 0, 1, 0, 1));
      chk("mul_disabled_ready", {31'd0, bus.in_ready}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
